// File: rtl/led_pkg.sv
// Shared types and default timing for the LED pulse stretcher.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } led_state_e;

    // 10 ms at 25 MHz
    localparam int unsigned C_ON_CYCLES_DEFAULT   = 250000;
    localparam int unsigned C_OFF_CYCLES_DEFAULT  = 250000;
    localparam int unsigned C_MAX_PENDING_DEFAULT = 7;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_timer.sv
// Loadable down-counter shared by the ON and GAP phases; expired_c flags a count of zero.
module led_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = (count_q == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle events into fixed-length LED blinks, queueing events that arrive mid-blink.
// Optional macro LED_RETRIGGER_EN: pulses during ON restart the ON time instead of queueing.
module led_pulse_stretcher
    import led_pkg::*;
#(
    parameter int unsigned c_ON_CYCLES   = C_ON_CYCLES_DEFAULT,
    parameter int unsigned c_OFF_CYCLES  = C_OFF_CYCLES_DEFAULT,
    parameter int unsigned c_MAX_PENDING = C_MAX_PENDING_DEFAULT
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Pulse,
    output logic o_LED,
    output logic o_Busy,
    output logic o_Overflow
);

    localparam int unsigned TMR_W  = cnt_width(max_u(c_ON_CYCLES, c_OFF_CYCLES));
    localparam int unsigned PEND_W = $clog2(c_MAX_PENDING + 1);

    // Timer holds remaining cycles minus one, so expiry marks the last cycle of a phase.
    localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(c_ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(c_OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(c_MAX_PENDING);

    led_state_e        state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired_c;
    logic              pend_full_c;

    led_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk       (i_Clk),
        .rst       (i_Reset),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .expired_c (tmr_expired_c)
    );

    assign pend_full_c = (pend_q == PEND_MAX);

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        tmr_load = 1'b0;
        tmr_val  = ON_LOAD;

        case (state_q)
            IDLE: begin
                if (i_Pulse) begin
                    state_d  = ON;
                    tmr_load = 1'b1;
                    tmr_val  = ON_LOAD;
                end
            end

            ON: begin
`ifdef LED_RETRIGGER_EN
                if (i_Pulse) begin
                    tmr_load = 1'b1;
                    tmr_val  = ON_LOAD;
                end else if (tmr_expired_c) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
`else
                if (i_Pulse) begin
                    if (pend_full_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_d = pend_q + PEND_W'(1);
                    end
                end
                if (tmr_expired_c) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
`endif
            end

            GAP: begin
                if (tmr_expired_c) begin
                    // A pulse here pairs with the outgoing decrement, so pending is left alone.
                    if (i_Pulse || (pend_q != '0)) begin
                        state_d  = ON;
                        tmr_load = 1'b1;
                        tmr_val  = ON_LOAD;
                        if (!i_Pulse) begin
                            pend_d = pend_q - PEND_W'(1);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else if (i_Pulse) begin
                    if (pend_full_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_d = pend_q + PEND_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign o_LED      = led_q;
    assign o_Busy     = busy_q;
    assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Scoreboard bench for led_pulse_stretcher: a timeline model predicts outputs, a monitor compares.
module tb_led_pulse_stretcher;

    localparam int ON_C  = 4;
    localparam int OFF_C = 3;
    localparam int MAX_P = 2;

    typedef struct packed {
        logic led;
        logic busy;
        logic ovf;
    } exp_t;

    logic i_Clk;
    logic i_Reset;
    logic i_Pulse;
    logic o_LED;
    logic o_Busy;
    logic o_Overflow;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    // Model: blink windows on a timeline of edge numbers.
    int n;
    int on_end;
    int pending;
    bit active;
    bit ovf;

    led_pulse_stretcher #(
        .c_ON_CYCLES   (ON_C),
        .c_OFF_CYCLES  (OFF_C),
        .c_MAX_PENDING (MAX_P)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Pulse    (i_Pulse),
        .o_LED      (o_LED),
        .o_Busy     (o_Busy),
        .o_Overflow (o_Overflow)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    task automatic model_edge(input bit p, input bit r);
        bit in_on;
        bit final_gap;
        n++;
        if (r) begin
            active  = 0;
            pending = 0;
            ovf     = 0;
            on_end  = 0;
        end else if (!active) begin
            if (p) begin
                active = 1;
                on_end = n + ON_C;
            end
        end else begin
            in_on     = (n <= on_end);
            final_gap = (n == on_end + OFF_C);
`ifdef LED_RETRIGGER_EN
            if (in_on && p) begin
                on_end = n + ON_C;
            end else
`endif
            if (final_gap) begin
                if (p || pending > 0) begin
                    if (!p) pending--;
                    on_end = n + ON_C;
                end else begin
                    active = 0;
                end
            end else if (p) begin
                if (pending < MAX_P) pending++;
                else ovf = 1;
            end
            if (in_on) begin end
        end
    endtask

    task automatic step(input bit p, input bit r);
        exp_t e;
        @(negedge i_Clk);
        i_Pulse = p;
        i_Reset = r;
        model_edge(p, r);
        e.led  = active && (n < on_end);
        e.busy = active;
        e.ovf  = ovf;
        exp_q.push_back(e);
    endtask

    task automatic play(input logic [63:0] pat, input int len);
        for (int i = 0; i < len; i++) step(pat[i], 1'b0);
    endtask

    // Monitor: compares the DUT after each edge against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (o_LED !== e.led) begin
                    fails++;
                    $display("FAIL led @%0t: got %b want %b", $time, o_LED, e.led);
                end
                tests++;
                if (o_Busy !== e.busy) begin
                    fails++;
                    $display("FAIL busy @%0t: got %b want %b", $time, o_Busy, e.busy);
                end
                tests++;
                if (o_Overflow !== e.ovf) begin
                    fails++;
                    $display("FAIL overflow @%0t: got %b want %b", $time, o_Overflow, e.ovf);
                end
            end
        end
    end

    initial begin
        tests   = 0;
        fails   = 0;
        n       = 0;
        on_end  = 0;
        pending = 0;
        active  = 0;
        ovf     = 0;
        i_Reset = 1'b1;
        i_Pulse = 1'b0;

        repeat (3) step(1'b0, 1'b1);

        // single blink
        play(64'h1, 12);
        // queue: pulses at ON cycle 1 and GAP cycle 2
        play(64'h43, 25);
        // overflow: four pulses during the first ON, then sticky check past IDLE
        play(64'h1F, 30);
        step(1'b0, 1'b1);
        // pulse in final GAP cycle with empty queue
        play(64'h81, 20);
        // pulse in final GAP cycle with a full queue
        play(64'h87, 40);
        // reset mid-ON with one pending
        play(64'h3, 2);
        step(1'b0, 1'b1);
        play(64'h0, 15);

        // randomized traffic with rare resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
        end
        play(64'h0, 30);

        @(negedge i_Clk);
        @(negedge i_Clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d left want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
